// File: rtl/pic_pkg.sv
// Shared definitions for the PIC CPU-side initiator.
// Holds the FSM state encoding, ICW bit positions, the timer width and the
// latched ICW set structure.
package pic_pkg;

    localparam int CNT_W     = 4;

    // ICW1 / vector bit positions
    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int ICW1_INIT = 4;
    localparam int VEC_T_MSB = 7;
    localparam int VEC_T_LSB = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_SETUP,
        ST_W_STROBE,
        ST_W_HOLD,
        ST_A_P1,
        ST_A_GAP,
        ST_A_P2,
        ST_A_REL
    } pic_state_e;

    typedef enum logic [1:0] {
        W_ICW1,
        W_ICW2,
        W_ICW3,
        W_ICW4
    } icw_idx_e;

    typedef struct packed {
        logic [7:0] icw1;
        logic [7:0] icw2;
        logic [7:0] icw3;
        logic [7:0] icw4;
    } icw_set_t;

endpackage

// File: rtl/pic_pulse_timer.sv
// Loadable down-counter timing the multi-cycle write and acknowledge states.
// Ports:
//   clk, rst  - clock, async active-high reset
//   load      - load load_val this cycle (wins over decrement)
//   load_val  - value to load (cycles remaining minus one)
//   zero      - counter is at zero; the current state ends this cycle
module pic_pulse_timer
    import pic_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pic_cpu_master.sv
// CPU-side initiator for the interrupt controller host interface.
// Writes the ICW1..ICW4 initialisation sequence over WR_n/A0/data and
// answers INT with the two-pulse INTA_n handshake, capturing the vector.
// Ports:
//   clk, rst                 - clock, async active-high reset
//   cfg_start, icw*_in       - request to program the controller + ICW values
//   cfg_busy/cfg_done        - sequence running / one-cycle completion pulse
//   configured               - sticky, set when a sequence completes
//   WR_n, A0, data_out/oe    - write port towards the controller
//   data_in                  - bus read value (vector)
//   INT, INTA_n              - interrupt request / acknowledge
//   vector, vector_valid     - captured vector and its update pulse
//   vec_err                  - vector type bits differ from ICW2 (only with
//                              PIC_VEC_CHECK_EN defined)
module pic_cpu_master
    import pic_pkg::*;
#(
    parameter int WR_PULSE   = 2,
    parameter int INTA_PULSE = 2,
    parameter int INTA_GAP   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_start,
    input  logic [7:0] icw1_in,
    input  logic [7:0] icw2_in,
    input  logic [7:0] icw3_in,
    input  logic [7:0] icw4_in,
    output logic       cfg_busy,
    output logic       cfg_done,
    output logic       configured,
    output logic       WR_n,
    output logic       A0,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic [7:0] data_in,
    input  logic       INT,
    output logic       INTA_n,
    output logic [7:0] vector,
    output logic       vector_valid
`ifdef PIC_VEC_CHECK_EN
    ,
    output logic       vec_err
`endif
);

    localparam logic [CNT_W-1:0] WR_LD  = CNT_W'(WR_PULSE - 1);
    localparam logic [CNT_W-1:0] P_LD   = CNT_W'(INTA_PULSE - 1);
    localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(INTA_GAP - 1);

    pic_state_e       state, state_nxt;
    icw_idx_e         word, word_nxt;
    icw_set_t         icw_q;
    logic             tmr_load, tmr_zero;
    logic [CNT_W-1:0] tmr_val;
    logic             accept, finish, capture;
    logic             more;
    icw_idx_e         next_word;
    logic [7:0]       cur_data;

    pic_pulse_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Which word follows the current one: ICW3 only in cascade mode,
    // ICW4 only when ICW1 asks for it.
    always_comb begin
        more      = 1'b0;
        next_word = W_ICW1;
        case (word)
            W_ICW1: begin more = 1'b1; next_word = W_ICW2; end
            W_ICW2: begin
                if (!icw_q.icw1[ICW1_SNGL]) begin
                    more = 1'b1; next_word = W_ICW3;
                end else if (icw_q.icw1[ICW1_IC4]) begin
                    more = 1'b1; next_word = W_ICW4;
                end
            end
            W_ICW3: begin
                if (icw_q.icw1[ICW1_IC4]) begin
                    more = 1'b1; next_word = W_ICW4;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            word  <= W_ICW1;
        end else begin
            state <= state_nxt;
            word  <= word_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        word_nxt  = word;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        accept    = 1'b0;
        finish    = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                // cfg_start wins over a simultaneous INT
                if (cfg_start) begin
                    accept    = 1'b1;
                    word_nxt  = W_ICW1;
                    state_nxt = ST_W_SETUP;
                end else if (configured && INT) begin
                    tmr_load  = 1'b1;
                    tmr_val   = P_LD;
                    state_nxt = ST_A_P1;
                end
            end
            ST_W_SETUP: begin
                tmr_load  = 1'b1;
                tmr_val   = WR_LD;
                state_nxt = ST_W_STROBE;
            end
            ST_W_STROBE: if (tmr_zero) state_nxt = ST_W_HOLD;
            ST_W_HOLD: begin
                if (more) begin
                    word_nxt  = next_word;
                    state_nxt = ST_W_SETUP;
                end else begin
                    finish    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_A_P1: if (tmr_zero) begin
                tmr_load  = 1'b1;
                tmr_val   = GAP_LD;
                state_nxt = ST_A_GAP;
            end
            ST_A_GAP: if (tmr_zero) begin
                tmr_load  = 1'b1;
                tmr_val   = P_LD;
                state_nxt = ST_A_P2;
            end
            ST_A_P2: if (tmr_zero) begin
                capture   = 1'b1;
                tmr_load  = 1'b1;
                tmr_val   = GAP_LD;
                state_nxt = ST_A_REL;
            end
            ST_A_REL: if (tmr_zero) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            icw_q        <= '0;
            cfg_done     <= 1'b0;
            configured   <= 1'b0;
            vector       <= 8'h00;
            vector_valid <= 1'b0;
        end else begin
            cfg_done     <= finish;
            vector_valid <= capture;
            if (accept) begin
                icw_q.icw1 <= icw1_in | (8'h01 << ICW1_INIT);
                icw_q.icw2 <= icw2_in;
                icw_q.icw3 <= icw3_in;
                icw_q.icw4 <= icw4_in;
                configured <= 1'b0;
            end else if (finish) begin
                configured <= 1'b1;
            end
            if (capture)
                vector <= data_in;
        end
    end

`ifdef PIC_VEC_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vec_err <= 1'b0;
        else
            vec_err <= capture &&
                (data_in[VEC_T_MSB:VEC_T_LSB] != icw_q.icw2[VEC_T_MSB:VEC_T_LSB]);
    end
`endif

    always_comb begin
        case (word)
            W_ICW1:  cur_data = icw_q.icw1;
            W_ICW2:  cur_data = icw_q.icw2;
            W_ICW3:  cur_data = icw_q.icw3;
            default: cur_data = icw_q.icw4;
        endcase
    end

    // Outputs decode straight from state so reset drops them immediately.
    assign cfg_busy = (state == ST_W_SETUP) || (state == ST_W_STROBE) ||
                      (state == ST_W_HOLD);
    assign data_oe  = cfg_busy;
    assign WR_n     = (state != ST_W_STROBE);
    assign A0       = cfg_busy && (word != W_ICW1);
    assign data_out = cfg_busy ? cur_data : 8'h00;
    assign INTA_n   = !((state == ST_A_P1) || (state == ST_A_P2));

endmodule

// File: tb/tb_pic_cpu_master.sv
module tb_pic_cpu_master;

    localparam int WRP = 2;
    localparam int IP  = 2;
    localparam int IG  = 2;
    localparam int L   = 2*IP + 2*IG;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_start = 1'b0;
    logic [7:0] icw1_in = 8'h00, icw2_in = 8'h00, icw3_in = 8'h00, icw4_in = 8'h00;
    logic       cfg_busy, cfg_done, configured;
    logic       WR_n, A0, data_oe;
    logic [7:0] data_out;
    logic [7:0] data_in = 8'h00;
    logic       INT = 1'b0;
    logic       INTA_n;
    logic [7:0] vector;
    logic       vector_valid;
`ifdef PIC_VEC_CHECK_EN
    logic       vec_err;
`endif

    pic_cpu_master #(.WR_PULSE(WRP), .INTA_PULSE(IP), .INTA_GAP(IG)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start),
        .icw1_in(icw1_in), .icw2_in(icw2_in), .icw3_in(icw3_in), .icw4_in(icw4_in),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .configured(configured),
        .WR_n(WR_n), .A0(A0), .data_out(data_out), .data_oe(data_oe),
        .data_in(data_in), .INT(INT), .INTA_n(INTA_n),
        .vector(vector), .vector_valid(vector_valid)
`ifdef PIC_VEC_CHECK_EN
        , .vec_err(vec_err)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_checks = 0;
    logic [7:0] last_icw2 = 8'h00;

    // Every WR_n falling edge records {data_oe, A0, data_out}.
    logic [9:0] wq[$];
    logic prev_wr = 1'b1;
    always @(negedge clk) begin
        if (!rst && prev_wr && !WR_n) wq.push_back({data_oe, A0, data_out});
        prev_wr = WR_n;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic run_cfg(input logic [7:0] i1, i2, i3, i4, input bit with_int);
        logic [9:0] exp_q[$];
        logic [9:0] got;
        int busy_n;
        bit done, inta_seen;
        exp_q.push_back({1'b1, 1'b0, i1 | 8'h10});
        exp_q.push_back({1'b1, 1'b1, i2});
        if (!i1[1]) exp_q.push_back({1'b1, 1'b1, i3});
        if (i1[0])  exp_q.push_back({1'b1, 1'b1, i4});
        wq.delete();
        last_icw2 = i2;
        @(posedge clk); #1;
        icw1_in = i1; icw2_in = i2; icw3_in = i3; icw4_in = i4;
        cfg_start = 1'b1;
        if (with_int) INT = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        // scramble inputs: the sequence must use the latched copies
        icw1_in = 8'($urandom); icw2_in = 8'($urandom);
        icw3_in = 8'($urandom); icw4_in = 8'($urandom);
        busy_n = 0; done = 0; inta_seen = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (cfg_busy) busy_n++;
            if (!INTA_n) inta_seen = 1;
            if (cfg_done) done = 1;
        end
        n_checks++;
        if (done !== 1'b1) $display("FAIL cfg_done_seen: got %0d expected 1", done);
        else n_pass++;
        n_checks++;
        if (busy_n !== exp_q.size()*(WRP+2))
            $display("FAIL cfg_len: got %0d busy cycles expected %0d", busy_n, exp_q.size()*(WRP+2));
        else n_pass++;
        n_checks++;
        if ({cfg_busy, configured, data_oe} !== 3'b010)
            $display("FAIL cfg_finish: got busy/configured/oe %b expected 010", {cfg_busy, configured, data_oe});
        else n_pass++;
        n_checks++;
        if (inta_seen !== 1'b0) $display("FAIL no_inta_during_cfg: got %0d expected 0", inta_seen);
        else n_pass++;
        n_checks++;
        if (wq.size() !== exp_q.size())
            $display("FAIL cfg_nwrites: got %0d expected %0d", wq.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < wq.size()) ? wq[i] : 10'bx;
            n_checks++;
            if (got !== exp_q[i])
                $display("FAIL cfg_write%0d: got oe/a0/data %h expected %h", i, got, exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic do_inta(input logic [7:0] d);
        logic [31:0] obs_i, obs_v, exp_i, exp_v;
        logic [7:0] vec_at;
        logic err_at;
        bit seen, oe_bad;
        obs_i = '0; obs_v = '0; exp_i = '0; exp_v = '0;
        vec_at = 8'hxx; err_at = 1'bx; oe_bad = 0; seen = 0;
        @(posedge clk); #1;
        data_in = d; INT = 1'b1;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (!INTA_n) seen = 1;
        end
        n_checks++;
        if (seen !== 1'b1) $display("FAIL inta_start: got %0d expected 1", seen);
        else n_pass++;
        INT = 1'b0;   // dropping INT mid-handshake must not abort it
        for (int i = 0; i < L; i++) begin
            if (i > 0) @(negedge clk);
            obs_i[i] = INTA_n;
            obs_v[i] = vector_valid;
            if (data_oe) oe_bad = 1;
            if (vector_valid) begin
                vec_at = vector;
`ifdef PIC_VEC_CHECK_EN
                err_at = vec_err;
`endif
            end
        end
        for (int i = 0; i < L; i++) begin
            exp_i[i] = !(i < IP || (i >= IP+IG && i < 2*IP+IG));
            exp_v[i] = (i == 2*IP+IG);
        end
        n_checks++;
        if (obs_i !== exp_i) $display("FAIL inta_shape: got %b expected %b", obs_i[L-1:0], exp_i[L-1:0]);
        else n_pass++;
        n_checks++;
        if (obs_v !== exp_v) $display("FAIL vector_valid: got %b expected %b", obs_v[L-1:0], exp_v[L-1:0]);
        else n_pass++;
        n_checks++;
        if (vec_at !== d) $display("FAIL vector_value: got %h expected %h", vec_at, d);
        else n_pass++;
        n_checks++;
        if (oe_bad !== 1'b0) $display("FAIL inta_oe: got %0d expected 0", oe_bad);
        else n_pass++;
`ifdef PIC_VEC_CHECK_EN
        n_checks++;
        if (err_at !== (d[7:3] != last_icw2[7:3]))
            $display("FAIL vec_err: got %b expected %b", err_at, (d[7:3] != last_icw2[7:3]));
        else n_pass++;
`endif
        @(negedge clk);
        n_checks++;
        if ({INTA_n, vector} !== {1'b1, d})
            $display("FAIL inta_idle_hold: got %b/%h expected 1/%h", INTA_n, vector, d);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({WR_n, INTA_n} !== 2'b11) $display("FAIL reset_strobes: got %b expected 11", {WR_n, INTA_n});
        else n_pass++;
        n_checks++;
        if ({A0, data_oe, data_out} !== 10'h0) $display("FAIL reset_bus: got %h expected 000", {A0, data_oe, data_out});
        else n_pass++;
        n_checks++;
        if ({cfg_busy, cfg_done, configured, vector_valid} !== 4'b0)
            $display("FAIL reset_flags: got %b expected 0000", {cfg_busy, cfg_done, configured, vector_valid});
        else n_pass++;
        n_checks++;
        if (vector !== 8'h00) $display("FAIL reset_vector: got %h expected 00", vector);
        else n_pass++;
`ifdef PIC_VEC_CHECK_EN
        n_checks++;
        if (vec_err !== 1'b0) $display("FAIL reset_vec_err: got %b expected 0", vec_err);
        else n_pass++;
`endif
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_int_unconfigured();
        bit low = 0;
        @(posedge clk); #1;
        INT = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!INTA_n) low = 1;
        end
        INT = 1'b0;
        n_checks++;
        if (low !== 1'b0) $display("FAIL int_unconfigured: got INTA low %0d expected 0", low);
        else n_pass++;
    endtask

    task automatic test_icw_single();
        run_cfg(8'h13, 8'h40, 8'hEE, 8'h01, 1'b0);
    endtask

    task automatic test_icw_cascade();
        run_cfg(8'h01, 8'($urandom), 8'h04, 8'($urandom), 1'b0);
    endtask

    task automatic test_inta();
        do_inta(8'h45);
        repeat (3) do_inta(8'($urandom));
    endtask

    task automatic test_random_cfg();
        repeat (4) begin
            run_cfg(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
            do_inta(8'($urandom));
        end
    endtask

    task automatic test_cfg_int_same();
        bit seen = 0;
        run_cfg(8'h1B, 8'h20, 8'h00, 8'h00, 1'b1);
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (!INTA_n) seen = 1;
        end
        INT = 1'b0;
        n_checks++;
        if (seen !== 1'b1) $display("FAIL inta_after_cfg: got %0d expected 1", seen);
        else n_pass++;
        repeat (L + 3) @(negedge clk);
    endtask

    task automatic test_vec_check();
        run_cfg(8'h13, 8'h40, 8'h00, 8'h01, 1'b0);
        do_inta(8'h8A);
        do_inta(8'h42);
    endtask

    task automatic test_reset_mid_write();
        int falls = 0;
        logic p = 1'b1;
        @(posedge clk); #1;
        icw1_in = 8'h11; icw2_in = 8'h48; icw3_in = 8'h02; icw4_in = 8'h03;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        for (int c = 0; c < 100 && falls < 2; c++) begin
            @(negedge clk);
            if (p && !WR_n) falls++;
            p = WR_n;
        end
        n_checks++;
        if (falls !== 2) $display("FAIL reach_icw2_strobe: got %0d expected 2", falls);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({WR_n, data_oe, cfg_busy, configured} !== 4'b1000)
            $display("FAIL reset_mid_write: got wr/oe/busy/cfg %b expected 1000", {WR_n, data_oe, cfg_busy, configured});
        else n_pass++;
        n_checks++;
        if (vector !== 8'h00) $display("FAIL reset_mid_vector: got %h expected 00", vector);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        run_cfg(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    endtask

    initial begin
        test_reset();
        test_int_unconfigured();
        test_icw_single();
        test_inta();
        test_icw_cascade();
        test_random_cfg();
        test_cfg_int_same();
        test_vec_check();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
